// File: rtl/ca_row_generator.sv
// Elementary cellular-automaton row producer: presents a 256-cell generation word by word
// to a frame writer over load/ack, then computes the next generation one word per cycle.
module ca_row_generator (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic [7:0]  rule,
  input  logic        seed_we,
  input  logic [4:0]  seed_addr,
  input  logic [7:0]  seed_data,
  input  logic        ack,
  input  logic [4:0]  col,
  output logic        load,
  output logic [7:0]  cell_word,
  output logic        busy,
  output logic [15:0] gen_count
);

  typedef enum logic [1:0] {IDLE, PRESENT, COMPUTE, SWAP} state_t;

  state_t        state_q, state_d;
  logic [255:0]  cur_row_q, cur_row_d;
  logic [255:0]  nxt_row_q, nxt_row_d;
  logic [7:0]    rule_q, rule_d;
  logic [4:0]    w_q, w_d;
  logic [15:0]   gen_q, gen_d;
  logic          load_q, load_d;
  logic [7:0]    new_word;
  logic [7:0]    ci, li, ri;

  // 8-bit cell indices make the ring wrap (cell 0 <-> cell 255) fall out of the arithmetic.
  always_comb begin
    new_word = '0;
    ci = '0;
    li = '0;
    ri = '0;
    for (int j = 0; j < 8; j++) begin
      ci = {w_q, j[2:0]};
      li = ci - 8'd1;
      ri = ci + 8'd1;
      new_word[j] = rule_q[{cur_row_q[li], cur_row_q[ci], cur_row_q[ri]}];
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    nxt_row_d = nxt_row_q;
    rule_d    = rule_q;
    w_d       = w_q;
    gen_d     = gen_q;
    load_d    = load_q;
    case (state_q)
      IDLE: begin
        if (seed_we) cur_row_d[{seed_addr, 3'b000} +: 8] = seed_data;
        if (run) begin
          rule_d  = rule;
          gen_d   = '0;
          load_d  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          load_d  = 1'b0;
          gen_d   = gen_q + 16'd1;
          w_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        nxt_row_d[{w_q, 3'b000} +: 8] = new_word;
        w_d = w_q + 5'd1;
        if (w_q == 5'd31) state_d = SWAP;
      end
      SWAP: begin
        cur_row_d = nxt_row_q;
        if (run) begin
          load_d  = 1'b1;
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cur_row_q <= '0;
      nxt_row_q <= '0;
      rule_q    <= '0;
      w_q       <= '0;
      gen_q     <= '0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      nxt_row_q <= nxt_row_d;
      rule_q    <= rule_d;
      w_q       <= w_d;
      gen_q     <= gen_d;
      load_q    <= load_d;
    end
  end

  assign load      = load_q;
  assign busy      = (state_q != IDLE);
  assign gen_count = gen_q;
  assign cell_word = cur_row_q[{col, 3'b000} +: 8];

endmodule

// File: doc/ca_row_generator.md
# ca_row_generator

Cellular-automaton row producer on the initiator side of the frame-store copy handshake. Holds the current 256-cell generation, presents it word-by-word to the VGA frame writer (`load`/`ack` with writer-driven column index), then computes the next generation with a Wolfram elementary rule over 32 cycles. It runs continuously while `run` is high, producing one row per handshake.

## Interface
Parameters: none. The geometry is fixed at 32 words × 8 bits, which gives 256 cells.

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `run`  in  1  level; enables generation
- `rule`  in  8  Wolfram rule number; sampled into `rule_q` on leaving IDLE
- `seed_we`  in  1  seed word write strobe; honoured only in IDLE
- `seed_addr`  in  5  seed word index
- `seed_data`  in  8  seed word
- `ack`  in  1  one-cycle pulse from the frame writer: row copied
- `col`  in  5  word index requested by the frame writer
- `load`  out  1  row ready for copy
- `cell_word`  out  8  `cur_row` word at `col`, combinational
- `busy`  out  1  state != IDLE
- `gen_count`  out  16  generations presented since the last start

## Operation
- **Storage and cell mapping**
  - Storage is `cur_row[255:0]` plus scratch `nxt_row[255:0]`.
  - Cell i is bit i. Word w holds cells 8w..8w+7, with bit j of word w = cell 8w+j.
  - `cell_word = cur_row[8*col +: 8]`.
- **Rule evaluation**
  - Neighbours wrap: left(i) = cell (i−1) mod 256, right(i) = cell (i+1) mod 256.
  - new(i) = `rule_q`[{left, self, right}], a 3-bit index with left as the MSB.
- **States**
  - IDLE
    - `seed_we` writes `seed_data` into `cur_row` word `seed_addr`.
    - If `run`=1: latch `rule`, clear `gen_count`, go to PRESENT, set `load`=1.
  - PRESENT
    - `load` is held at 1.
    - `cur_row` is frozen.
    - On `ack`: `load`<=0, `gen_count`+=1 (16-bit wrap), `w`<=0, go to COMPUTE.
  - COMPUTE
    - Each cycle, `nxt_row` word `w` <= rule applied to cells 8w..8w+7 of `cur_row`.
    - `w`+=1. After w=31, go to SWAP.
  - SWAP
    - `cur_row`<=`nxt_row`.
    - If `run`=1, go to PRESENT with `load`<=1. Otherwise go to IDLE.
- **Boundary behaviour**
  - `ack` outside PRESENT is ignored.
  - `seed_we` outside IDLE is ignored.
  - `run` is sampled only in IDLE and SWAP. Dropping it mid-row completes the current compute and then idles.
  - `rule` changes take effect only at the next IDLE exit.
  - Word 0 uses cell 255 as the left neighbour of cell 0. Word 31 uses cell 0 as the right neighbour of cell 255.
  - IDLE with `run`=1 and `seed_we`=1 in the same cycle: the seed write happens, and the state still advances.

## Timing
- **Reset values:** state=IDLE, `load`=0, `busy`=0, `gen_count`=0, `cur_row`=0, `nxt_row`=0, `rule_q`=0, `w`=0.
- **Reset mid-operation:** asynchronous return to the above values at any time. The seed must be rewritten afterwards.
- **Registered signals:** `load` is registered. `cell_word` is combinational from `col`, with zero latency. The writer samples it in the same cycle it drives `col`.
- **Start:** IDLE with `run`=1 at edge E gives `load`=1 from E+1.
- **Handshake:**
  - `ack` sampled at edge A gives `load`=0 from A+1.
  - This guarantees the writer's idle state sees `load` low and does not re-copy.
- **Row-to-row gap:** COMPUTE spans A+1..A+32, SWAP is at A+33, and `load`=1 again from A+34.
- **Stalling:** there is no timeout. `load` stays high indefinitely until `ack`, for example while the writer is stalled on its key at row 255.

## Test plan
- **Seed and first row:**
  - Stimulus: reset, write word 16 = 0x01 (cell 128), `rule`=90, `run`=1.
  - First row presented: word16=0x01, all other words 0.
  - After `ack`: word15=0x80, word16=0x02, others 0. `gen_count`=1.
- **Wrap-around:**
  - Stimulus: seed word0=0x01 (cell 0), `rule`=90.
  - Required: gen 1 has word0=0x02 and word31=0x80 (cells 1 and 255).
- **Identity and clear:**
  - Stimulus: seed words 0..31 with 0xA5, `rule`=204.
  - Required: the row is unchanged for 3 generations.
  - Then with `rule`=0 after re-idle: the next row is all 0.
- **Stalled ack:**
  - Stimulus: hold `ack` low for 100 cycles while sweeping `col` 0..31 repeatedly.
  - Required: `load`=1 throughout and `cell_word` stable per col.
  - Then pulse `ack`: `load`=0 the next cycle, and `load`=1 again exactly 34 cycles after the ack edge.
- **Run drop:**
  - Stimulus: deassert `run` during COMPUTE.
  - Required: SWAP completes, state goes to IDLE, `busy`=0, `load` stays 0, and `cur_row` holds the new generation.
  - Spurious `ack` in IDLE: no effect.
- **Reset mid-COMPUTE:**
  - Stimulus: assert `reset_n`=0 at w=10.
  - Required: immediate `load`=0, `busy`=0, `gen_count`=0, `cell_word`=0 for all col.
